// File: rtl/sb_hfosc_pkg.sv
// Shared types and helpers for the high-frequency oscillator model.
// The power state enum and the divider half-period helper live here.
package sb_hfosc_pkg;

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      POWERUP = 2'd1,
      READY   = 2'd2
   } hfosc_state_t;

   // Half-period of CLKHF, in reference clock edges, for a given divide select.
   function automatic int unsigned hp(input int unsigned div);
      return 32'd1 << div;
   endfunction

endpackage

// File: rtl/hfosc_clkdiv.sv
// Divider for CLKHF with glitch-free stop: a high phase always runs its full
// half-period before the output parks low; dropping run kills the output at once.
module hfosc_clkdiv
   import sb_hfosc_pkg::*;
#(
   parameter int unsigned DIV = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic en,
   output logic CLKHF
);

   localparam int unsigned CNT_W = (DIV > 1) ? DIV : 1;
   localparam int unsigned HALF  = hp(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] div_cnt_reg;
   logic [CNT_W-1:0] div_cnt_next;
   logic             clkhf_reg;
   logic             clkhf_next;

   always_comb begin
      div_cnt_next = div_cnt_reg;
      clkhf_next   = clkhf_reg;
      if (!run) begin
         div_cnt_next = '0;
         clkhf_next   = 1'b0;
      end else if (en || clkhf_reg) begin
         // A high phase keeps counting after en drops, so it is never shortened.
         if (div_cnt_reg == CNT_LAST) begin
            div_cnt_next = '0;
            clkhf_next   = ~clkhf_reg;
         end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
         end
      end else begin
         div_cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg <= '0;
         clkhf_reg   <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         clkhf_reg   <= clkhf_next;
      end
   end

   assign CLKHF = clkhf_reg;

endmodule

// File: rtl/sb_hfosc.sv
// Behavioural iCE40 HF oscillator: power-up sequencing FSM with a saturating
// delay counter, feeding a gated divider that produces CLKHF.
module sb_hfosc
   import sb_hfosc_pkg::*;
#(
   parameter logic [1:0]  CLKHF_DIV       = 2'b00,
   parameter int unsigned PU_DELAY_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic CLKHFPU,
   input  logic CLKHFEN,
   output logic CLKHF
);

   localparam int unsigned PU_W = $clog2(PU_DELAY_CYCLES + 1);
   localparam logic [PU_W-1:0] PU_LAST = PU_W'(PU_DELAY_CYCLES - 1);
   localparam logic [PU_W-1:0] PU_MAX  = PU_W'(PU_DELAY_CYCLES);

   hfosc_state_t    state_reg;
   hfosc_state_t    state_next;
   logic [PU_W-1:0] pu_cnt_reg;
   logic [PU_W-1:0] pu_cnt_next;
   logic            run;

   always_comb begin
      state_next  = state_reg;
      pu_cnt_next = pu_cnt_reg;
      case (state_reg)
         OFF: begin
            pu_cnt_next = '0;
            if (CLKHFPU) state_next = POWERUP;
         end
         POWERUP: begin
            if (!CLKHFPU) begin
               state_next  = OFF;
               pu_cnt_next = '0;
            end else begin
               if (pu_cnt_reg != PU_MAX) pu_cnt_next = pu_cnt_reg + 1'b1;
               if (pu_cnt_reg == PU_LAST) state_next = READY;
            end
         end
         READY: begin
            if (!CLKHFPU) begin
               state_next  = OFF;
               pu_cnt_next = '0;
            end
         end
         default: begin
            state_next  = OFF;
            pu_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= OFF;
         pu_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         pu_cnt_reg <= pu_cnt_next;
      end
   end

   // Power-down must zero CLKHF on the same edge, so run looks at the live request.
   assign run = (state_reg == READY) && CLKHFPU;

   hfosc_clkdiv #(
      .DIV (int'(CLKHF_DIV))
   ) u_clkdiv (
      .clk   (clk),
      .rst   (rst),
      .run   (run),
      .en    (CLKHFEN),
      .CLKHF (CLKHF)
   );

endmodule

// File: tb/tb_sb_hfosc.sv
// Self-checking bench: three oscillators (divide 0/1/2) share stimulus and are
// compared against an edge-counting reference model.
module tb_sb_hfosc;

   localparam int PD = 8;
   localparam int HALF [3] = '{1, 2, 4};

   logic clk;
   logic rst;
   logic pu;
   logic en;
   logic hf [3];

   int n_tests;
   int n_fail;

   // Reference model: consecutive powered edges plus level/age of each output phase.
   int pu_run;
   bit m_lvl [3];
   int m_age [3];

   sb_hfosc #(.CLKHF_DIV(2'd0), .PU_DELAY_CYCLES(PD)) u_div0 (
      .clk(clk), .rst(rst), .CLKHFPU(pu), .CLKHFEN(en), .CLKHF(hf[0]));
   sb_hfosc #(.CLKHF_DIV(2'd1), .PU_DELAY_CYCLES(PD)) u_div1 (
      .clk(clk), .rst(rst), .CLKHFPU(pu), .CLKHFEN(en), .CLKHF(hf[1]));
   sb_hfosc #(.CLKHF_DIV(2'd2), .PU_DELAY_CYCLES(PD)) u_div2 (
      .clk(clk), .rst(rst), .CLKHFPU(pu), .CLKHFEN(en), .CLKHF(hf[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      bit active;
      @(posedge clk);
      // Ready once PD edges have elapsed after the edge that left OFF.
      active = (pu_run >= PD + 1) && pu;
      for (int i = 0; i < 3; i++) begin
         if (rst || !active) begin
            m_lvl[i] = 1'b0;
            m_age[i] = 0;
         end else if (en || m_lvl[i]) begin
            m_age[i]++;
            if (m_age[i] == HALF[i]) begin
               m_lvl[i] = ~m_lvl[i];
               m_age[i] = 0;
            end
         end else begin
            m_age[i] = 0;
         end
      end
      if (rst || !pu) pu_run = 0;
      else if (pu_run < PD + 1) pu_run++;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pu = 1'b1; en = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (hf[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset div%0d: CLKHF=%b expected 0", i, hf[i]);
         end
      end
      rst = 1'b0; pu = 1'b0; en = 1'b0;
      tick();
   endtask

   task automatic test_powerup();
      int first [3];
      first = '{-1, -1, -1};
      pu = 1'b1; en = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== m_lvl[i]) begin
               n_fail++;
               $display("FAIL powerup div%0d edge %0d: CLKHF=%b expected %b", i, k, hf[i], m_lvl[i]);
            end
            if (first[i] < 0 && hf[i] === 1'b1) first[i] = k;
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (first[i] != PD + 1 + HALF[i]) begin
            n_fail++;
            $display("FAIL first_rise div%0d: edge=%0d expected %0d", i, first[i], PD + 1 + HALF[i]);
         end
      end
   endtask

   task automatic test_period();
      int  len [3];
      bit  prev [3];
      bit  seen [3];
      for (int i = 0; i < 3; i++) begin
         len[i] = 0; prev[i] = hf[i]; seen[i] = 1'b0;
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== m_lvl[i]) begin
               n_fail++;
               $display("FAIL period div%0d: CLKHF=%b expected %b", i, hf[i], m_lvl[i]);
            end
            if (hf[i] !== prev[i]) begin
               if (seen[i]) begin
                  n_tests++;
                  if (len[i] != HALF[i]) begin
                     n_fail++;
                     $display("FAIL phase_len div%0d: len=%0d expected %0d", i, len[i], HALF[i]);
                  end
               end
               seen[i] = 1'b1;
               len[i]  = 1;
               prev[i] = hf[i];
            end else begin
               len[i]++;
            end
         end
      end
   endtask

   task automatic test_enable_stop();
      int  k;
      int  hi;
      bit  prev;
      k = 0;
      prev = hf[2];
      while (!(hf[2] === 1'b1 && !prev) && k < 20) begin
         prev = hf[2];
         tick();
         k++;
      end
      n_tests++;
      if (k >= 20) begin
         n_fail++;
         $display("FAIL en_stop_wait: no CLKHF rise within 20 edges, got %0d expected <20", k);
      end
      en = 1'b0;
      hi = 1;
      for (int j = 0; j < 12; j++) begin
         tick();
         if (hf[2] === 1'b1) hi++;
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== m_lvl[i]) begin
               n_fail++;
               $display("FAIL en_stop div%0d: CLKHF=%b expected %b", i, hf[i], m_lvl[i]);
            end
         end
      end
      n_tests++;
      if (hi != 4 || hf[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL en_stop_high: high=%0d final=%b expected 4 and 0", hi, hf[2]);
      end
      en = 1'b1;
      k = 0;
      while (hf[2] !== 1'b1 && k < 20) begin
         tick();
         k++;
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== m_lvl[i]) begin
               n_fail++;
               $display("FAIL re_enable div%0d: CLKHF=%b expected %b", i, hf[i], m_lvl[i]);
            end
         end
      end
      n_tests++;
      if (k != 4) begin
         n_fail++;
         $display("FAIL re_enable_latency: edges=%0d expected 4", k);
      end
   endtask

   task automatic test_powerup_abort();
      int first;
      rst = 1'b1; tick();
      rst = 1'b0; pu = 1'b0; en = 1'b1; tick();
      for (int k = 0; k < 10; k++) begin
         pu = (k < 5);
         tick();
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== 1'b0 || m_lvl[i]) begin
               n_fail++;
               $display("FAIL pu_abort div%0d: CLKHF=%b model=%b expected 0", i, hf[i], m_lvl[i]);
            end
         end
      end
      pu = 1'b1;
      first = -1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (first < 0 && hf[0] === 1'b1) first = k;
      end
      n_tests++;
      if (first != PD + 2) begin
         n_fail++;
         $display("FAIL pu_restart: first rise edge=%0d expected %0d", first, PD + 2);
      end
   endtask

   task automatic test_powerdown_rst();
      int k;
      k = 0;
      while (hf[1] !== 1'b1 && k < 30) begin tick(); k++; end
      n_tests++;
      if (k >= 30) begin
         n_fail++;
         $display("FAIL pd_wait: no high phase within 30 edges, got %0d expected <30", k);
      end
      pu = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL powerdown div%0d edge %0d: CLKHF=%b expected 0", i, j, hf[i]);
            end
         end
      end
      pu = 1'b1;
      k = 0;
      while (hf[1] !== 1'b1 && k < 30) begin tick(); k++; end
      n_tests++;
      if (k >= 30) begin
         n_fail++;
         $display("FAIL rst_wait: no high phase within 30 edges, got %0d expected <30", k);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (hf[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst div%0d: CLKHF=%b expected 0", i, hf[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 39) == 0) pu = ~pu;
         if ($urandom_range(0, 7) == 0)  en = ~en;
         tick();
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (hf[i] !== m_lvl[i]) begin
               n_fail++;
               $display("FAIL random div%0d step %0d: CLKHF=%b expected %b", i, k, hf[i], m_lvl[i]);
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      pu_run  = 0;
      for (int i = 0; i < 3; i++) begin m_lvl[i] = 1'b0; m_age[i] = 0; end
      rst = 1'b1; pu = 1'b0; en = 1'b0;
      test_reset();
      test_powerup();
      test_period();
      test_enable_stop();
      test_powerup_abort();
      test_powerdown_rst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
